multiplexor_rr: RTL and testbench

MULTIPLEXOR_RR -- requirements
Module: multiplexor_rr

---
 rtl/multiplexor_rr.sv | 148 ++++++++++++++
 tb/tb_multiplexor_rr.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/multiplexor_rr.sv
// multiplexor_rr
// ---------------------------------------------------------------------------
// Selects one of CHANNELS input words per cycle and registers it onto a single
// valid/ready output stage.
//
// Arbitration modes:
//   - Fixed mode (i_mode=0): the channel named by i_con is selected.
//   - Round-robin mode (i_mode=1): a rotating pointer decides which channel
//     is selected next.
//
// Grants are issued only when the output register can take a new word.
// A new word can be taken when the register is empty or is being consumed
// in the same cycle. Because of this, back-to-back traffic runs at one word
// per cycle with no bubbles.
//
// Optional feature: when MULTIPLEXOR_RR_COUNT_EN is defined, a saturating
// 16-bit count of consumed words is added on o_count.
//
// Ports:
//   clk      in   rising-edge clock
//   rs       in   asynchronous reset, active low
//   i_data   in   flattened channel data, channel k at [k*WIDTH +: WIDTH]
//   i_valid  in   per-channel data valid
//   o_grant  out  per-channel accept (one-hot or zero), combinational
//   i_con    in   channel select used in fixed mode
//   i_mode   in   0 = fixed select, 1 = round-robin
//   o_data   out  registered output word
//   o_sel    out  channel index that produced o_data
//   o_valid  out  output register holds an unconsumed word
//   i_ready  in   downstream accepts o_data this cycle
//   o_count  out  (MULTIPLEXOR_RR_COUNT_EN only) consumed-word count, saturating
// ---------------------------------------------------------------------------
module multiplexor_rr #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rs,
  input  logic [CHANNELS*WIDTH-1:0] i_data,
  input  logic [CHANNELS-1:0]       i_valid,
  output logic [CHANNELS-1:0]       o_grant,
  input  logic [SEL_W-1:0]          i_con,
  input  logic                      i_mode,
  output logic [WIDTH-1:0]          o_data,
  output logic [SEL_W-1:0]          o_sel,
  output logic                      o_valid,
  input  logic                      i_ready
`ifdef MULTIPLEXOR_RR_COUNT_EN
  ,
  output logic [15:0]               o_count
`endif
);

  logic             load;
  logic             grant_any;
  logic [SEL_W-1:0] grant_idx;
  logic [SEL_W-1:0] cand;
  logic [SEL_W-1:0] ptr;
  logic [WIDTH-1:0] sel_data;

  // Arbitration.
  // The search starts at ptr+1 and wraps modulo CHANNELS. Because CHANNELS
  // is a power of two, that wrap is just SEL_W-bit overflow. The final
  // iteration (i = CHANNELS) lands back on ptr itself. That way a lone
  // requester on the last-granted channel still gets served.
  // Holding rs low suppresses every grant, even before the register reset
  // has taken effect.
  always_comb begin
    load      = !o_valid || i_ready;
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    if (rs && load) begin
      if (!i_mode) begin
        grant_any = i_valid[i_con];
        grant_idx = i_con;
      end else begin
        for (int i = 1; i <= CHANNELS; i++) begin
          cand = ptr + SEL_W'(i);
          if (!grant_any && i_valid[cand]) begin
            grant_any = 1'b1;
            grant_idx = cand;
          end
        end
      end
    end
  end

  // Expand the granted index into the one-hot accept vector.
  always_comb begin
    o_grant = '0;
    if (grant_any) begin
      o_grant[grant_idx] = 1'b1;
    end
  end

  // Data mux for the granted channel.
  // This is written as a compare per channel rather than a variable
  // part-select, so each slice is a constant range.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (grant_idx == SEL_W'(k)) begin
        sel_data = i_data[k*WIDTH +: WIDTH];
      end
    end
  end

  // Output register and round-robin pointer.
  // A grant already implies load, so a transfer either fills an empty
  // register or replaces a word being consumed this same edge.
  // The pointer starts at CHANNELS-1 so that channel 0 is searched first.
  // It only moves on round-robin grants, so fixed-mode traffic leaves the
  // rotation where it was.
  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_sel   <= '0;
      ptr     <= SEL_W'(CHANNELS - 1);
    end else begin
      if (grant_any) begin
        o_valid <= 1'b1;
        o_data  <= sel_data;
        o_sel   <= grant_idx;
        if (i_mode) begin
          ptr <= grant_idx;
        end
      end else if (i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

`ifdef MULTIPLEXOR_RR_COUNT_EN
  // Consumed-word counter. It sticks at all-ones instead of wrapping, so a
  // long run never reads back as a small number.
  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      o_count <= '0;
    end else if (o_valid && i_ready && (o_count != 16'hFFFF)) begin
      o_count <= o_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multiplexor_rr.sv
// tb_multiplexor_rr
// ---------------------------------------------------------------------------
// Self-checking bench for multiplexor_rr (CHANNELS=4, WIDTH=8).
// A behavioural reference model computes the expected grant and output
// register contents from the arbitration rules. Directed scenarios come
// first, followed by a randomized run that includes asynchronous resets.
// ---------------------------------------------------------------------------
module tb_multiplexor_rr;

  localparam int W  = 8;
  localparam int CH = 4;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            rs;
  logic [CH*W-1:0] i_data;
  logic [CH-1:0]   i_valid;
  logic [CH-1:0]   o_grant;
  logic [SW-1:0]   i_con;
  logic            i_mode;
  logic [W-1:0]    o_data;
  logic [SW-1:0]   o_sel;
  logic            o_valid;
  logic            i_ready;
`ifdef MULTIPLEXOR_RR_COUNT_EN
  logic [15:0]     o_count;
`endif

  multiplexor_rr #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk     (clk),
    .rs      (rs),
    .i_data  (i_data),
    .i_valid (i_valid),
    .o_grant (o_grant),
    .i_con   (i_con),
    .i_mode  (i_mode),
    .o_data  (o_data),
    .o_sel   (o_sel),
    .o_valid (o_valid),
    .i_ready (i_ready)
`ifdef MULTIPLEXOR_RR_COUNT_EN
    ,
    .o_count (o_count)
`endif
  );

  always #5 clk = ~clk;

  int n_compared   = 0;
  int n_mismatched = 0;

  // reference model state
  logic          m_valid;
  logic [W-1:0]  m_data;
  int            m_sel;
  int            m_ptr;
  int            m_count;
  logic [CH-1:0] last_grant;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_sel   = 0;
    m_ptr   = CH - 1;
    m_count = 0;
  endtask

  // Entered 2 time units after a rising edge with the inputs already driven.
  // Checks at +3, advances the model on the edge, and returns at +2.
  task automatic run_cycle();
    logic          any;
    int            idx;
    logic          ld;
    logic [CH-1:0] exp_grant;
    #1;
    ld  = !m_valid || i_ready;
    any = 1'b0;
    idx = 0;
    if (rs && ld) begin
      if (!i_mode) begin
        any = i_valid[i_con];
        idx = int'(i_con);
      end else begin
        for (int i = 1; i <= CH; i++) begin
          int c;
          c = (m_ptr + i) % CH;
          if (!any && i_valid[c]) begin
            any = 1'b1;
            idx = c;
          end
        end
      end
    end
    exp_grant = '0;
    if (any) exp_grant[idx] = 1'b1;
    last_grant = o_grant;
    check("grant", 64'(o_grant), 64'(exp_grant));
    check("valid", 64'(o_valid), 64'(m_valid));
    check("data",  64'(o_data),  64'(m_data));
    check("sel",   64'(o_sel),   64'(m_sel));
`ifdef MULTIPLEXOR_RR_COUNT_EN
    check("count", 64'(o_count), 64'(m_count));
`endif
    @(posedge clk);
    if (!rs) begin
      model_reset();
    end else begin
      if (m_valid && i_ready && m_count < 65535) m_count++;
      if (any) begin
        m_valid = 1'b1;
        m_data  = i_data[idx*W +: W];
        m_sel   = idx;
        if (i_mode) m_ptr = idx;
      end else if (i_ready) begin
        m_valid = 1'b0;
      end
    end
    #2;
  endtask

  task automatic pulse_reset();
    rs = 1'b0;
    #1;
    check("rst_now_valid", 64'(o_valid), 64'd0);
    check("rst_now_data",  64'(o_data),  64'd0);
    check("rst_now_sel",   64'(o_sel),   64'd0);
    check("rst_now_grant", 64'(o_grant), 64'd0);
    model_reset();
    run_cycle();
    rs = 1'b1;
  endtask

  initial begin
    rs      = 1'b0;
    i_valid = 4'hF;
    i_mode  = 1'b1;
    i_con   = '0;
    i_data  = 32'hDEADBEEF;
    i_ready = 1'b1;
    model_reset();
    @(posedge clk);
    #2;

    // held in reset with every channel requesting
    repeat (3) begin
      run_cycle();
      check("rst_grant", 64'(last_grant), 64'd0);
      check("rst_valid", 64'(o_valid), 64'd0);
      check("rst_data",  64'(o_data),  64'd0);
    end
    rs = 1'b1;

    // fixed select of channel 2
    i_mode  = 1'b0;
    i_con   = 2'd2;
    i_data  = 32'h44A52211;
    i_valid = 4'b0100;
    run_cycle();
    check("fixed_grant", 64'(last_grant), 64'h4);
    check("fixed_data",  64'(o_data),  64'hA5);
    check("fixed_sel",   64'(o_sel),   64'd2);
    check("fixed_valid", 64'(o_valid), 64'd1);

    // round-robin fairness from reset
    pulse_reset();
    i_mode  = 1'b1;
    i_valid = 4'hF;
    i_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      i_data = $urandom;
      run_cycle();
      check("rr_sel",   64'(o_sel),   64'(i % 4));
      check("rr_valid", 64'(o_valid), 64'd1);
    end

    // backpressure, then release picks the next channel in order
    i_ready = 1'b0;
    i_valid = 4'b0011;
    repeat (3) begin
      run_cycle();
      check("bp_grant", 64'(last_grant), 64'd0);
      check("bp_sel",   64'(o_sel),   64'd3);
    end
    i_ready = 1'b1;
    run_cycle();
    check("bp_release_grant", 64'(last_grant), 64'h1);

    // sparse wrap from pointer 3
    pulse_reset();
    i_valid = 4'b0100;
    run_cycle();
    check("wrap_grant_ch2", 64'(last_grant), 64'h4);
    i_valid = 4'b0101;
    run_cycle();
    check("wrap_grant_ch0", 64'(last_grant), 64'h1);
    check("wrap_sel",       64'(o_sel),      64'd0);

    // randomized traffic with occasional mid-run resets
    for (int n = 0; n < 400; n++) begin
      i_data  = $urandom;
      i_valid = 4'($urandom_range(0, 15));
      i_mode  = 1'($urandom_range(0, 1));
      i_con   = 2'($urandom_range(0, 3));
      i_ready = ($urandom_range(0, 9) < 7);
      if (n % 97 == 50) pulse_reset();
      run_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
